// File: rtl/fifo_arb_pkg.sv
// Shared types and counter widths for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      BURST   = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   localparam int unsigned WORD_CNT_W   = 8;
   localparam int unsigned SETTLE_CNT_W = 4;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: favours the requester that did not win last.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last_winner,
   output logic       winner,
   output logic       any_req
);

   logic other;

   assign other   = ~last_winner;
   assign any_req = |req;

   always_comb begin
      winner = last_winner;
      if (req[other]) begin
         winner = other;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the FIFO write port between two producers,
// with a settle gap before each grant and almost_full back-pressure.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned DATA_W        = 8,
   parameter int unsigned BURST_LEN     = 16,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [1:0]        req,
   input  logic [1:0]        wr_valid,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic [DATA_W-1:0] wr_data1,
   output logic [1:0]        grant,
   output logic [1:0]        wr_ack,
   input  logic              almost_full,
   input  logic              full,
   output logic              fifo_wr_en,
   output logic [DATA_W-1:0] fifo_wdata,
   output logic              busy
);

   localparam logic [WORD_CNT_W:0]   BURST_LIM  = (WORD_CNT_W+1)'(BURST_LEN);
   localparam logic [SETTLE_CNT_W:0] SETTLE_LIM = (SETTLE_CNT_W+1)'(SETTLE_CYCLES);

   arb_state_t              state, state_nxt;
   logic                    winner, winner_nxt;
   logic                    last_winner, last_winner_nxt;
   logic [WORD_CNT_W-1:0]   word_cnt, word_cnt_nxt;
   logic [SETTLE_CNT_W-1:0] settle_cnt, settle_cnt_nxt;
   logic [1:0]              grant_nxt;
   logic                    wr_en_nxt;
   logic [DATA_W-1:0]       wdata_nxt;
   logic                    busy_nxt;

   logic                    pick;
   logic                    any_req;
   logic                    accept_ok;
   logic                    accept;
   logic                    settle_done;
   logic                    burst_last;
   logic [DATA_W-1:0]       sel_data;

   rr_pick2 u_rr_pick2 (
      .req         (req),
      .last_winner (last_winner),
      .winner      (pick),
      .any_req     (any_req)
   );

   assign accept_ok   = (state == BURST) & ~almost_full & ~full;
   assign wr_ack      = grant & wr_valid & {2{accept_ok}};
   assign accept      = |wr_ack;
   assign sel_data    = winner ? wr_data1 : wr_data0;
   assign settle_done = ({1'b0, settle_cnt} + (SETTLE_CNT_W+1)'(1)) >= SETTLE_LIM;
   assign burst_last  = ({1'b0, word_cnt} + (WORD_CNT_W+1)'(1)) >= BURST_LIM;

   // Next-state and registered-output decode
   always_comb begin
      state_nxt       = state;
      winner_nxt      = winner;
      last_winner_nxt = last_winner;
      word_cnt_nxt    = word_cnt;
      settle_cnt_nxt  = settle_cnt;
      grant_nxt       = grant;
      wr_en_nxt       = accept;
      wdata_nxt       = accept ? sel_data : fifo_wdata;

      case (state)
         IDLE: begin
            grant_nxt = 2'b00;
            if (any_req & ~almost_full & ~full) begin
               winner_nxt     = pick;
               settle_cnt_nxt = '0;
               state_nxt      = SETTLE;
            end
         end
         SETTLE: begin
            if (!req[winner]) begin
               state_nxt = IDLE;
            end else if (settle_done) begin
               grant_nxt    = winner ? 2'b10 : 2'b01;
               word_cnt_nxt = '0;
               state_nxt    = BURST;
            end else begin
               settle_cnt_nxt = settle_cnt + SETTLE_CNT_W'(1);
            end
         end
         BURST: begin
            if (accept) begin
               word_cnt_nxt = word_cnt + WORD_CNT_W'(1);
            end
            // A stall (wr_valid low) neither counts nor ends the burst
            if ((accept & burst_last) | ~req[winner] | almost_full | full) begin
               grant_nxt       = 2'b00;
               last_winner_nxt = winner;
               state_nxt       = RELEASE;
            end
         end
         RELEASE: begin
            grant_nxt = 2'b00;
            state_nxt = IDLE;
         end
         default: begin
            grant_nxt = 2'b00;
            state_nxt = IDLE;
         end
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

   // State and output registers; reset drops any word in flight
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state       <= IDLE;
         winner      <= 1'b0;
         last_winner <= 1'b1;
         word_cnt    <= '0;
         settle_cnt  <= '0;
         grant       <= 2'b00;
         fifo_wr_en  <= 1'b0;
         fifo_wdata  <= '0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         winner      <= winner_nxt;
         last_winner <= last_winner_nxt;
         word_cnt    <= word_cnt_nxt;
         settle_cnt  <= settle_cnt_nxt;
         grant       <= grant_nxt;
         fifo_wr_en  <= wr_en_nxt;
         fifo_wdata  <= wdata_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic.
module tb_fifo_wr_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned BL = 4;
   localparam int unsigned SC = 4;

   logic          sys_clk = 1'b0;
   logic          sys_rst;
   logic [1:0]    req;
   logic [1:0]    wr_valid;
   logic [DW-1:0] wr_data0;
   logic [DW-1:0] wr_data1;
   logic [1:0]    grant;
   logic [1:0]    wr_ack;
   logic          almost_full;
   logic          full;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wdata;
   logic          busy;

   int total = 0;
   int bad   = 0;

   // observations of the current cycle and reference-model expectations
   logic [1:0]    obs_grant, obs_ack, exp_ack;
   logic          obs_en, obs_busy;
   logic [DW-1:0] obs_data;
   logic          exp_en = 1'b0;
   logic [DW-1:0] exp_data = '0;
   logic          cur_exp_en;
   logic [DW-1:0] cur_exp_data;

   fifo_wr_arbiter #(.DATA_W(DW), .BURST_LEN(BL), .SETTLE_CYCLES(SC)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .req         (req),
      .wr_valid    (wr_valid),
      .wr_data0    (wr_data0),
      .wr_data1    (wr_data1),
      .grant       (grant),
      .wr_ack      (wr_ack),
      .almost_full (almost_full),
      .full        (full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wdata  (fifo_wdata),
      .busy        (busy)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Observe at negedge, advance the write-pipeline model at posedge, return just after it
   task automatic step();
      @(negedge sys_clk);
      obs_grant    = grant;
      obs_ack      = wr_ack;
      obs_en       = fifo_wr_en;
      obs_data     = fifo_wdata;
      obs_busy     = busy;
      cur_exp_en   = exp_en;
      cur_exp_data = exp_data;
      exp_ack      = obs_grant & wr_valid & {2{~almost_full & ~full}};
      @(posedge sys_clk);
      if (sys_rst) begin
         exp_en   = 1'b0;
         exp_data = '0;
      end else begin
         exp_en = |exp_ack;
         if (exp_ack[1]) exp_data = wr_data1;
         else if (exp_ack[0]) exp_data = wr_data0;
      end
      #1;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1; req = 2'b00; wr_valid = 2'b00;
      almost_full = 1'b0; full = 1'b0; wr_data0 = '0; wr_data1 = '0;
      step();
      step();
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      wr_valid = 2'b11;
      step();
      total++; if (obs_grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", obs_grant); end
      total++; if (obs_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", obs_en); end
      total++; if (obs_data !== 8'h00) begin bad++; $display("FAIL reset_wdata got=%h exp=00", obs_data); end
      total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", obs_busy); end
      total++; if (obs_ack !== 2'b00) begin bad++; $display("FAIL reset_ack got=%b exp=00", obs_ack); end
   endtask

   task automatic test_first_grant();
      int  n = 0;
      bit  got = 0;
      do_reset();
      req = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant !== 2'b00) begin got = 1; break; end
         n++;
      end
      total++; if (!got || n != SC + 1) begin bad++; $display("FAIL first_grant_delay got=%0d exp=%0d", n, SC + 1); end
      total++; if (obs_grant !== 2'b01) begin bad++; $display("FAIL first_grant_value got=%b exp=01", obs_grant); end
      total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL first_grant_busy got=%b exp=1", obs_busy); end
   endtask

   task automatic test_full_burst();
      int acks = 0, writes = 0, gap = 0, phase = 0;
      do_reset();
      req = 2'b01; wr_valid = 2'b01; wr_data0 = 8'h10;
      for (int i = 0; i < 80 && phase != 3; i++) begin
         step();
         total++; if (obs_ack !== exp_ack) begin bad++; $display("FAIL burst_ack got=%b exp=%b", obs_ack, exp_ack); end
         total++; if (obs_en !== cur_exp_en || (cur_exp_en && obs_data !== cur_exp_data)) begin
            bad++; $display("FAIL burst_write got=%b/%h exp=%b/%h", obs_en, obs_data, cur_exp_en, cur_exp_data);
         end
         if (obs_en) begin
            total++; if (obs_data !== 8'(8'h10 + writes)) begin bad++; $display("FAIL burst_data got=%h exp=%h", obs_data, 8'(8'h10 + writes)); end
            writes++;
         end
         case (phase)
            0: if (obs_grant !== 2'b00) phase = 1;
            1: if (obs_grant === 2'b00) begin phase = 2; gap = 1; end
            2: if (obs_grant === 2'b00) gap++;
               else begin
                  phase = 3;
                  total++; if (obs_grant !== 2'b01) begin bad++; $display("FAIL burst_regrant got=%b exp=01", obs_grant); end
               end
            default: ;
         endcase
         if (phase == 1 && obs_ack[0]) acks++;
         wr_data0 = 8'(8'h10 + acks);
      end
      total++; if (phase != 3) begin bad++; $display("FAIL burst_timeout got=%0d exp=3", phase); end
      total++; if (acks != BL) begin bad++; $display("FAIL burst_acks got=%0d exp=%0d", acks, BL); end
      total++; if (writes != BL) begin bad++; $display("FAIL burst_writes got=%0d exp=%0d", writes, BL); end
      total++; if (gap != SC + 2) begin bad++; $display("FAIL burst_gap got=%0d exp=%0d", gap, SC + 2); end
   endtask

   task automatic test_round_robin();
      logic [1:0] rr_exp [3] = '{2'b01, 2'b10, 2'b01};
      logic [1:0] prev = 2'b00;
      int ngr = 0, zero_run = 0;
      do_reset();
      req = 2'b11; wr_valid = 2'b11; wr_data0 = 8'hA5; wr_data1 = 8'h5A;
      for (int i = 0; i < 150 && ngr < 3; i++) begin
         step();
         total++; if (obs_ack !== exp_ack) begin bad++; $display("FAIL rr_ack got=%b exp=%b", obs_ack, exp_ack); end
         total++; if (obs_en !== cur_exp_en || (cur_exp_en && obs_data !== cur_exp_data)) begin
            bad++; $display("FAIL rr_write got=%b/%h exp=%b/%h", obs_en, obs_data, cur_exp_en, cur_exp_data);
         end
         if (obs_grant !== 2'b00 && prev === 2'b00) begin
            total++; if (obs_grant !== rr_exp[ngr]) begin bad++; $display("FAIL rr_order got=%b exp=%b", obs_grant, rr_exp[ngr]); end
            if (ngr > 0) begin
               total++; if (zero_run < SC + 1) begin bad++; $display("FAIL rr_gap got=%0d exp>=%0d", zero_run, SC + 1); end
            end
            ngr++;
         end
         zero_run = (obs_grant === 2'b00) ? zero_run + 1 : 0;
         prev = obs_grant;
      end
      total++; if (ngr != 3) begin bad++; $display("FAIL rr_timeout got=%0d exp=3", ngr); end
   endtask

   task automatic test_almost_full();
      int acks = 0, writes = 0, n = 0;
      bit got = 0;
      do_reset();
      req = 2'b01; wr_valid = 2'b01; wr_data0 = 8'h40;
      for (int i = 0; i < 30 && acks < 2; i++) begin
         step();
         if (obs_en) writes++;
         if (obs_ack[0]) acks++;
         wr_data0 = 8'(8'h40 + acks);
      end
      almost_full = 1'b1;
      step();
      if (obs_en) writes++;
      total++; if (obs_grant !== 2'b01) begin bad++; $display("FAIL af_grant_same_cycle got=%b exp=01", obs_grant); end
      total++; if (obs_ack !== 2'b00) begin bad++; $display("FAIL af_ack_drop got=%b exp=00", obs_ack); end
      for (int i = 0; i < 15; i++) begin
         step();
         if (obs_en) begin
            total++; if (obs_data !== 8'h41) begin bad++; $display("FAIL af_late_data got=%h exp=41", obs_data); end
            writes++;
         end
         total++; if (obs_grant !== 2'b00) begin bad++; $display("FAIL af_no_regrant got=%b exp=00", obs_grant); end
      end
      total++; if (writes != 2) begin bad++; $display("FAIL af_writes got=%0d exp=2", writes); end
      total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL af_idle_busy got=%b exp=0", obs_busy); end
      total++; if (obs_data !== 8'h41) begin bad++; $display("FAIL af_hold_data got=%h exp=41", obs_data); end
      almost_full = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant !== 2'b00) begin got = 1; break; end
         n++;
      end
      total++; if (!got || n != SC + 1) begin bad++; $display("FAIL af_regrant_delay got=%0d exp=%0d", n, SC + 1); end
   endtask

   task automatic test_stall_drop();
      int acks = 0, more = 0;
      bit got = 0;
      do_reset();
      req = 2'b01; wr_valid = 2'b01; wr_data0 = 8'h60;
      for (int i = 0; i < 30 && acks < 2; i++) begin
         step();
         if (obs_ack[0]) acks++;
      end
      wr_valid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (obs_grant !== 2'b01 || obs_ack !== 2'b00) begin
            bad++; $display("FAIL stall_hold got=%b/%b exp=01/00", obs_grant, obs_ack);
         end
      end
      wr_valid = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant === 2'b00) begin got = 1; break; end
         if (obs_ack[0]) more++;
      end
      total++; if (!got || more != BL - 2) begin bad++; $display("FAIL stall_word_cnt got=%0d exp=%0d", more, BL - 2); end

      do_reset();
      got = 0;
      req = 2'b11; wr_valid = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant !== 2'b00) begin got = 1; break; end
      end
      total++; if (!got || obs_grant !== 2'b01) begin bad++; $display("FAIL drop_first got=%b exp=01", obs_grant); end
      step();
      req = 2'b10; wr_valid = 2'b00;
      step();
      step();
      total++; if (obs_grant !== 2'b00) begin bad++; $display("FAIL drop_clear got=%b exp=00", obs_grant); end
      got = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant !== 2'b00) begin got = 1; break; end
      end
      total++; if (!got || obs_grant !== 2'b10) begin bad++; $display("FAIL drop_next_winner got=%b exp=10", obs_grant); end
   endtask

   task automatic test_reset_burst();
      bit got = 0;
      do_reset();
      req = 2'b01; wr_valid = 2'b01; wr_data0 = 8'h77;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant !== 2'b00) begin got = 1; break; end
      end
      total++; if (!got || obs_ack !== 2'b01) begin bad++; $display("FAIL rstb_accept got=%b exp=01", obs_ack); end
      sys_rst = 1'b1;
      step();
      total++; if (obs_en !== 1'b1 || obs_data !== 8'h77) begin bad++; $display("FAIL rstb_write got=%b/%h exp=1/77", obs_en, obs_data); end
      sys_rst = 1'b0;
      step();
      total++; if (obs_en !== 1'b0 || obs_grant !== 2'b00 || obs_busy !== 1'b0) begin
         bad++; $display("FAIL rstb_after got=%b/%b/%b exp=0/00/0", obs_en, obs_grant, obs_busy);
      end
      got = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (obs_grant !== 2'b00) begin got = 1; break; end
      end
      wr_data0 = 8'h99;
      sys_rst = 1'b1;
      step();
      total++; if (!got || obs_ack !== 2'b01) begin bad++; $display("FAIL rstb_inflight_ack got=%b exp=01", obs_ack); end
      sys_rst = 1'b0;
      step();
      total++; if (obs_en !== 1'b0 || obs_grant !== 2'b00) begin bad++; $display("FAIL rstb_dropped got=%b/%b exp=0/00", obs_en, obs_grant); end
   endtask

   task automatic test_random();
      logic [1:0] prev = 2'b00;
      int zero_run = 0, words = 0;
      bit seen = 0;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) req = 2'($urandom);
         wr_valid    = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom);
         almost_full = ($urandom_range(0, 9) == 0);
         full        = ($urandom_range(0, 29) == 0);
         wr_data0    = 8'($urandom);
         wr_data1    = 8'($urandom);
         step();
         total++; if (obs_ack !== exp_ack) begin bad++; $display("FAIL rnd_ack got=%b exp=%b", obs_ack, exp_ack); end
         total++; if (obs_en !== cur_exp_en || (cur_exp_en && obs_data !== cur_exp_data)) begin
            bad++; $display("FAIL rnd_write got=%b/%h exp=%b/%h", obs_en, obs_data, cur_exp_en, cur_exp_data);
         end
         total++; if (obs_grant === 2'b11 || (obs_grant !== 2'b00 && prev !== 2'b00 && obs_grant !== prev)) begin
            bad++; $display("FAIL rnd_grant_overlap got=%b prev=%b", obs_grant, prev);
         end
         if (obs_grant !== 2'b00 && prev === 2'b00) begin
            if (seen) begin
               total++; if (zero_run < SC + 1) begin bad++; $display("FAIL rnd_gap got=%0d exp>=%0d", zero_run, SC + 1); end
            end
            seen = 1;
         end
         words = (obs_grant === 2'b00) ? 0 : words + ((|obs_ack) ? 1 : 0);
         total++; if (words > BL) begin bad++; $display("FAIL rnd_burst_len got=%0d exp<=%0d", words, BL); end
         zero_run = (obs_grant === 2'b00) ? zero_run + 1 : 0;
         prev = obs_grant;
      end
   endtask

   initial begin
      test_reset();
      test_first_grant();
      test_full_burst();
      test_round_robin();
      test_almost_full();
      test_stall_drop();
      test_reset_burst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
